linear_regression_predictor: RTL and testbench

- Inference-side counterpart of the regression estimator. It takes the fitted coefficients (theta0, theta1) from the estimator's output interface and streams predictions z_hat = theta0 + theta1*x for an incoming x sample stream.
- Sits downstream of the estimator and shares its signed fixed-width integer conventions.
- Valid/ready on both sample ports; the 2-stage pipeline stalls fully on backpressure.

---
 rtl/linear_regression_predictor_pkg.sv | 14 +
 rtl/linear_regression_mac_stage.sv | 76 +++++++
 rtl/linear_regression_predictor.sv | 145 ++++++++++++++
 tb/tb_linear_regression_predictor.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/linear_regression_predictor_pkg.sv
// Shared definitions for the linear-regression predictor and the estimator integration:
// default widths and the coefficient FSM state encoding.
package linear_regression_predictor_pkg;

   localparam int LRP_DATA_WIDTH = 32;
   localparam int LRP_CNT_WIDTH  = 16;

   typedef enum logic [1:0] {
      NO_COEF  = 2'd0,
      IDLE     = 2'd1,
      IN_FRAME = 2'd2
   } lrp_state_e;

endpackage

// File: rtl/linear_regression_mac_stage.sv
// Two-stage multiply-add pipeline: stage 1 registers theta1*x (full width) plus theta0,
// stage 2 registers the wrapped sum. Both stages advance together on i_en.
module linear_regression_mac_stage
   import linear_regression_predictor_pkg::*;
#(
   parameter int DATA_WIDTH = LRP_DATA_WIDTH
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic                  i_en,
   input  logic                  i_vld,
   input  logic [DATA_WIDTH-1:0] i_x,
   input  logic [DATA_WIDTH-1:0] i_theta0,
   input  logic [DATA_WIDTH-1:0] i_theta1,
   input  logic                  i_last,
   output logic [DATA_WIDTH-1:0] o_z,
   output logic                  o_vld,
   output logic                  o_last
);

   localparam int PROD_WIDTH = 2 * DATA_WIDTH;

   logic                  s1_vld_q, s1_vld_d;
   logic                  s1_last_q, s1_last_d;
   logic [PROD_WIDTH-1:0] prod_q, prod_d;
   logic [DATA_WIDTH-1:0] theta0_q, theta0_d;
   logic                  s2_vld_q, s2_vld_d;
   logic                  s2_last_q, s2_last_d;
   logic [DATA_WIDTH-1:0] z_q, z_d;

   always_comb begin
      s1_vld_d  = s1_vld_q;
      s1_last_d = s1_last_q;
      prod_d    = prod_q;
      theta0_d  = theta0_q;
      s2_vld_d  = s2_vld_q;
      s2_last_d = s2_last_q;
      z_d       = z_q;
      if (i_en) begin
         s1_vld_d  = i_vld;
         s1_last_d = i_vld && i_last;
         // Sign-extending both operands makes the low 2*DATA_WIDTH product bits the signed product.
         prod_d    = {{DATA_WIDTH{i_theta1[DATA_WIDTH-1]}}, i_theta1}
                   * {{DATA_WIDTH{i_x[DATA_WIDTH-1]}}, i_x};
         theta0_d  = i_theta0;
         s2_vld_d  = s1_vld_q;
         s2_last_d = s1_last_q;
         z_d       = DATA_WIDTH'(prod_q + {{DATA_WIDTH{theta0_q[DATA_WIDTH-1]}}, theta0_q});
      end
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         s1_vld_q  <= 1'b0;
         s1_last_q <= 1'b0;
         prod_q    <= '0;
         theta0_q  <= '0;
         s2_vld_q  <= 1'b0;
         s2_last_q <= 1'b0;
         z_q       <= '0;
      end else begin
         s1_vld_q  <= s1_vld_d;
         s1_last_q <= s1_last_d;
         prod_q    <= prod_d;
         theta0_q  <= theta0_d;
         s2_vld_q  <= s2_vld_d;
         s2_last_q <= s2_last_d;
         z_q       <= z_d;
      end
   end

   assign o_z    = z_q;
   assign o_vld  = s2_vld_q;
   assign o_last = s2_last_q;

endmodule

// File: rtl/linear_regression_predictor.sv
// Streams z_hat = theta0 + theta1*x. Coefficient updates arriving mid-frame are held in a
// shadow register and take effect at the frame boundary.
module linear_regression_predictor
   import linear_regression_predictor_pkg::*;
#(
   parameter int DATA_WIDTH = LRP_DATA_WIDTH,
   parameter int CNT_WIDTH  = LRP_CNT_WIDTH
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic [DATA_WIDTH-1:0] i_theta0_in,
   input  logic [DATA_WIDTH-1:0] i_theta1_in,
   input  logic                  i_theta_vld,
   input  logic [DATA_WIDTH-1:0] i_samples_x_in,
   input  logic                  i_samples_x_vld,
   input  logic                  i_samples_x_last,
   output logic                  o_samples_x_rdy,
   output logic [DATA_WIDTH-1:0] o_z_out,
   output logic                  o_z_vld,
   output logic                  o_z_last,
   input  logic                  i_z_rdy,
   output logic                  o_coef_loaded,
   output logic [CNT_WIDTH-1:0]  o_frame_count
);

   lrp_state_e            state_q, state_d;
   logic [DATA_WIDTH-1:0] theta0_q, theta0_d;
   logic [DATA_WIDTH-1:0] theta1_q, theta1_d;
   logic [DATA_WIDTH-1:0] shadow0_q, shadow0_d;
   logic [DATA_WIDTH-1:0] shadow1_q, shadow1_d;
   logic                  shadow_vld_q, shadow_vld_d;
   logic [CNT_WIDTH-1:0]  count_q, count_d;

   logic z_vld;
   logic advance;
   logic coef_loaded;
   logic x_rdy;
   logic x_fire;
   logic x_last_fire;

   assign advance     = !z_vld || i_z_rdy;
   assign coef_loaded = (state_q != NO_COEF);
   assign x_rdy       = coef_loaded && advance;
   assign x_fire      = i_samples_x_vld && x_rdy;
   assign x_last_fire = x_fire && i_samples_x_last;

   always_comb begin
      state_d      = state_q;
      theta0_d     = theta0_q;
      theta1_d     = theta1_q;
      shadow0_d    = shadow0_q;
      shadow1_d    = shadow1_q;
      shadow_vld_d = shadow_vld_q;
      case (state_q)
         NO_COEF: begin
            if (i_theta_vld) begin
               theta0_d = i_theta0_in;
               theta1_d = i_theta1_in;
               state_d  = IDLE;
            end
         end
         IDLE: begin
            if (i_theta_vld) begin
               theta0_d = i_theta0_in;
               theta1_d = i_theta1_in;
            end
            if (x_fire && !i_samples_x_last) begin
               state_d = IN_FRAME;
            end
         end
         IN_FRAME: begin
            // A strobe coinciding with the last beat wins over any older shadow value.
            if (x_last_fire) begin
               state_d      = IDLE;
               shadow_vld_d = 1'b0;
               if (i_theta_vld) begin
                  theta0_d = i_theta0_in;
                  theta1_d = i_theta1_in;
               end else if (shadow_vld_q) begin
                  theta0_d = shadow0_q;
                  theta1_d = shadow1_q;
               end
            end else if (i_theta_vld) begin
               shadow0_d    = i_theta0_in;
               shadow1_d    = i_theta1_in;
               shadow_vld_d = 1'b1;
            end
         end
         default: begin
            state_d = NO_COEF;
         end
      endcase
   end

   always_comb begin
      count_d = count_q;
      if (x_last_fire) begin
         count_d = '0;
      end else if (x_fire) begin
         count_d = count_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         state_q      <= NO_COEF;
         theta0_q     <= '0;
         theta1_q     <= '0;
         shadow0_q    <= '0;
         shadow1_q    <= '0;
         shadow_vld_q <= 1'b0;
         count_q      <= '0;
      end else begin
         state_q      <= state_d;
         theta0_q     <= theta0_d;
         theta1_q     <= theta1_d;
         shadow0_q    <= shadow0_d;
         shadow1_q    <= shadow1_d;
         shadow_vld_q <= shadow_vld_d;
         count_q      <= count_d;
      end
   end

   linear_regression_mac_stage #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_mac (
      .i_clock  (i_clock),
      .i_reset  (i_reset),
      .i_en     (advance),
      .i_vld    (x_fire),
      .i_x      (i_samples_x_in),
      .i_theta0 (theta0_q),
      .i_theta1 (theta1_q),
      .i_last   (i_samples_x_last),
      .o_z      (o_z_out),
      .o_vld    (z_vld),
      .o_last   (o_z_last)
   );

   assign o_z_vld         = z_vld;
   assign o_samples_x_rdy = x_rdy;
   assign o_coef_loaded   = coef_loaded;
   assign o_frame_count   = count_q;

endmodule

// File: tb/tb_linear_regression_predictor.sv
// Scoreboard bench for linear_regression_predictor: directed vectors push hand-computed
// predictions into a queue; a monitor pops and compares each delivered output.
module tb_linear_regression_predictor;

   logic        i_clock;
   logic        i_reset;
   logic [31:0] i_theta0_in;
   logic [31:0] i_theta1_in;
   logic        i_theta_vld;
   logic [31:0] i_samples_x_in;
   logic        i_samples_x_vld;
   logic        i_samples_x_last;
   logic        o_samples_x_rdy;
   logic [31:0] o_z_out;
   logic        o_z_vld;
   logic        o_z_last;
   logic        i_z_rdy;
   logic        o_coef_loaded;
   logic [15:0] o_frame_count;

   linear_regression_predictor #(
      .DATA_WIDTH (32),
      .CNT_WIDTH  (16)
   ) dut (
      .i_clock          (i_clock),
      .i_reset          (i_reset),
      .i_theta0_in      (i_theta0_in),
      .i_theta1_in      (i_theta1_in),
      .i_theta_vld      (i_theta_vld),
      .i_samples_x_in   (i_samples_x_in),
      .i_samples_x_vld  (i_samples_x_vld),
      .i_samples_x_last (i_samples_x_last),
      .o_samples_x_rdy  (o_samples_x_rdy),
      .o_z_out          (o_z_out),
      .o_z_vld          (o_z_vld),
      .o_z_last         (o_z_last),
      .i_z_rdy          (i_z_rdy),
      .o_coef_loaded    (o_coef_loaded),
      .o_frame_count    (o_frame_count)
   );

   typedef struct {
      logic [31:0] z;
      logic        last;
      int          acc;
      bit          chk_lat;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   initial i_clock = 1'b0;
   always #5 i_clock = ~i_clock;
   always @(posedge i_clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Monitor: pops one expectation per delivered prediction and checks stall stability.
   initial begin : monitor
      logic        prev_hold;
      logic [31:0] prev_z;
      logic        prev_last;
      exp_t        e;
      prev_hold = 1'b0;
      prev_z    = '0;
      prev_last = 1'b0;
      forever begin
         @(negedge i_clock);
         #3;
         if (prev_hold) begin
            chk("hold_vld", 32'(o_z_vld), 32'd1);
            chk("hold_z", o_z_out, prev_z);
            chk("hold_last", 32'(o_z_last), 32'(prev_last));
         end
         prev_hold = o_z_vld && !i_z_rdy && !i_reset;
         prev_z    = o_z_out;
         prev_last = o_z_last;
         if (o_z_vld && i_z_rdy) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_z actual=%0h required=no_output", o_z_out);
            end else begin
               e = sb_q.pop_front();
               chk("z", o_z_out, e.z);
               chk("z_last", 32'(o_z_last), 32'(e.last));
               if (e.chk_lat) chk("latency", 32'(cyc - e.acc), 32'd2);
            end
         end
      end
   end

   // Called at a falling edge; returns at the falling edge after the sample was accepted.
   task automatic send(input logic [31:0] x, input logic last, input logic [31:0] ez,
                       input bit lat, input bit strobe = 1'b0,
                       input logic [31:0] t0 = '0, input logic [31:0] t1 = '0);
      bit ok;
      ok = 1'b0;
      i_samples_x_in   = x;
      i_samples_x_last = last;
      i_samples_x_vld  = 1'b1;
      for (int t = 0; t < 40 && !ok; t++) begin
         #1;
         if (o_samples_x_rdy) begin
            ok = 1'b1;
            if (strobe) begin
               i_theta0_in = t0;
               i_theta1_in = t1;
               i_theta_vld = 1'b1;
            end
            sb_q.push_back('{z: ez, last: last, acc: cyc, chk_lat: lat});
         end
         @(negedge i_clock);
      end
      i_theta_vld = 1'b0;
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL send_timeout actual=rdy_low required=accept x=%0h", x);
         i_samples_x_vld = 1'b0;
      end
   endtask

   task automatic load(input logic [31:0] t0, input logic [31:0] t1);
      i_samples_x_vld = 1'b0;
      i_theta0_in     = t0;
      i_theta1_in     = t1;
      i_theta_vld     = 1'b1;
      @(negedge i_clock);
      i_theta_vld     = 1'b0;
   endtask

   task automatic drain();
      i_samples_x_vld = 1'b0;
      for (int t = 0; t < 50 && sb_q.size() != 0; t++) @(negedge i_clock);
      repeat (2) @(negedge i_clock);
      chk("drain_pending", 32'(sb_q.size()), 32'd0);
   endtask

   task automatic no_coef_window(input logic [31:0] x);
      i_samples_x_in   = x;
      i_samples_x_last = 1'b0;
      i_samples_x_vld  = 1'b1;
      for (int t = 0; t < 10; t++) begin
         #1;
         chk("nocoef_rdy", 32'(o_samples_x_rdy), 32'd0);
         chk("nocoef_zvld", 32'(o_z_vld), 32'd0);
         @(negedge i_clock);
      end
      i_samples_x_vld = 1'b0;
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      i_reset          = 1'b1;
      i_theta0_in      = '0;
      i_theta1_in      = '0;
      i_theta_vld      = 1'b0;
      i_samples_x_in   = '0;
      i_samples_x_vld  = 1'b0;
      i_samples_x_last = 1'b0;
      i_z_rdy          = 1'b1;

      // Reset state
      #12;
      chk("rst_zvld", 32'(o_z_vld), 32'd0);
      chk("rst_z", o_z_out, 32'd0);
      chk("rst_zlast", 32'(o_z_last), 32'd0);
      chk("rst_rdy", 32'(o_samples_x_rdy), 32'd0);
      chk("rst_coef", 32'(o_coef_loaded), 32'd0);
      chk("rst_count", 32'(o_frame_count), 32'd0);
      @(negedge i_clock);
      i_reset = 1'b0;
      @(negedge i_clock);

      // No coefficients: x is refused; then basic frame with theta(3,2)
      no_coef_window(32'd1);
      load(32'd3, 32'd2);
      #1 chk("coef_loaded", 32'(o_coef_loaded), 32'd1);
      send(32'd1, 1'b0, 32'd5, 1'b1);
      send(32'd2, 1'b0, 32'd7, 1'b1);
      #1 chk("count_mid", 32'(o_frame_count), 32'd2);
      send(32'd3, 1'b1, 32'd9, 1'b1);
      drain();
      chk("count_after_last", 32'(o_frame_count), 32'd0);

      // Negative values and two's-complement wrap, loaded directly in IDLE
      load(32'hFFFF_FFF6, 32'hFFFF_FFFC);
      send(32'd5, 1'b1, 32'hFFFF_FFE2, 1'b1);
      load(32'd0, 32'd2);
      send(32'h8000_0000, 1'b1, 32'd0, 1'b1);
      load(32'h7FFF_FFFF, 32'd1);
      send(32'd1, 1'b1, 32'h8000_0000, 1'b1);
      drain();

      // Backpressure: stall 5 cycles mid-stream
      load(32'd3, 32'd2);
      send(32'd1, 1'b0, 32'd5, 1'b0);
      send(32'd2, 1'b0, 32'd7, 1'b0);
      send(32'd3, 1'b0, 32'd9, 1'b0);
      i_z_rdy          = 1'b0;
      i_samples_x_in   = 32'd4;
      i_samples_x_last = 1'b0;
      i_samples_x_vld  = 1'b1;
      for (int t = 0; t < 5; t++) begin
         #1 chk("stall_rdy", 32'(o_samples_x_rdy), 32'd0);
         @(negedge i_clock);
      end
      i_z_rdy = 1'b1;
      send(32'd4, 1'b0, 32'd11, 1'b0);
      send(32'd5, 1'b0, 32'd13, 1'b0);
      send(32'd6, 1'b1, 32'd15, 1'b0);
      drain();

      // Mid-frame update goes to the shadow; the second strobe overwrites the first
      send(32'd1, 1'b0, 32'd5, 1'b1);
      load(32'd100, 32'd100);
      load(32'd0, 32'd10);
      send(32'd2, 1'b0, 32'd7, 1'b1);
      send(32'd3, 1'b1, 32'd9, 1'b1);
      send(32'd1, 1'b1, 32'd10, 1'b1);
      drain();

      // Strobe coincident with last-beat acceptance
      send(32'd1, 1'b0, 32'd10, 1'b1);
      send(32'd2, 1'b1, 32'd20, 1'b1, 1'b1, 32'd5, 32'd1);
      send(32'd7, 1'b1, 32'd12, 1'b1);
      drain();

      // Reset with two samples in flight
      send(32'd1, 1'b0, 32'd6, 1'b1);
      send(32'd2, 1'b0, 32'd7, 1'b1);
      i_reset         = 1'b1;
      i_samples_x_vld = 1'b0;
      sb_q.delete();
      #1;
      chk("midrst_zvld", 32'(o_z_vld), 32'd0);
      chk("midrst_count", 32'(o_frame_count), 32'd0);
      chk("midrst_coef", 32'(o_coef_loaded), 32'd0);
      @(negedge i_clock);
      i_reset = 1'b0;
      @(negedge i_clock);
      no_coef_window(32'd9);
      load(32'd5, 32'd1);
      send(32'd9, 1'b1, 32'd14, 1'b1);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
